shader_load_scheduler: RTL and testbench
========================================

Name: shader_load_scheduler

Overview:
- Shares the shader instruction memory (a 16-entry circular shift register) between two requesters: the raster execution path and the SPI instruction loader.
- Raster shifting always has priority. SPI instruction writes are buffered in a FIFO and committed only in allowed windows, so a visible pixel never executes a half-rotated or partially loaded program.
- Sits between spi_receiver and shader_memory in the shader top level, and drives shader_memory's shift/load/instr inputs.

Parameters:
- NUM_INSTR, 16, shader memory depth; also the program length used for commit counting.
- DEPTH, 16, write FIFO depth in entries (power of two, >= 2).
- INSTR_W, 8, instruction width.
- ATOMIC, 1, 1 = commit only in vblank with hold released; 0 = commit whenever raster is not executing.

Ports:
- clk_i, in, 1: system clock.
- rst_i, in, 1: synchronous reset, active-high.
- wr_valid_i, in, 1: SPI loader offers an instruction.
- wr_instr_i, in, INSTR_W: offered instruction.
- wr_ready_o, out, 1: FIFO can accept; equals !full.
- hold_i, in, 1: SPI program transfer in progress.
- exec_req_i, in, 1: raster needs a memory shift this cycle.
- vblank_i, in, 1: vertical blanking.
- flush_i, in, 1: discard all buffered writes.
- mem_shift_o, out, 1: to shader_memory shift_i.
- mem_load_o, out, 1: to shader_memory load_i.
- mem_instr_o, out, INSTR_W: to shader_memory instr_i.
- busy_o, out, 1: state != IDLE.
- prog_done_o, out, 1: one-cycle pulse when a full program has been committed.
- overflow_o, out, 1: sticky; a write was offered while full.

Behaviour:
- Reset (rst_i sampled high at clk_i edge):
  - FIFO empty; state IDLE; commit counter 0; overflow_o=0; prog_done_o=0.
  - Combinational outputs follow from the empty FIFO: wr_ready_o=1, mem_load_o=0, mem_shift_o=exec_req_i.
  - Reset mid-drain drops all pending entries; already committed entries remain in memory.
- Push: wr_valid_i && !full. The entry is visible at the FIFO head the next cycle, so minimum latency from accept to mem_load_o is 1 cycle.
  - Push while full is rejected, even if a pop occurs the same cycle; overflow_o sets and stays set until rst_i.
- Window:
  - ATOMIC=1: window = vblank_i && !hold_i && !exec_req_i.
  - ATOMIC=0: window = !exec_req_i.
- pop = !empty && window && state != IDLE.
- Memory outputs (combinational from registered FIFO/state plus exec_req_i):
  - mem_shift_o = exec_req_i | pop.
  - mem_load_o = pop.
  - mem_instr_o = FIFO head, or 0 when empty.
- exec_req_i high always wins; pop is suppressed that cycle. Memory alignment is thus preserved because every execute cycle shifts exactly once.
- FSM:
  - IDLE: go to WAIT when the FIFO becomes non-empty.
  - WAIT: go to DRAIN when window=1.
  - DRAIN: pop one entry per cycle. Go to WAIT if window drops while non-empty. Go to IDLE when the last entry pops (empty next cycle) and no push is pending.
- Simultaneous push and pop: both happen and the count is unchanged.
- Commit counter (mod NUM_INSTR) increments per pop. On wrap NUM_INSTR-1 -> 0, prog_done_o pulses high for the following cycle.
- flush_i: next cycle FIFO empty, state IDLE, commit counter 0. A push in the same cycle as flush_i is discarded. No pop occurs in the flush cycle.
- In ATOMIC=1, if vblank_i ends mid-program, draining pauses in WAIT and resumes next vblank. The testbench must flag this case; the SPI side is expected to keep DEPTH >= NUM_INSTR so one vblank suffices.

Decomposition:
- Shared package shader_pkg: INSTR_W, NUM_INSTR constants, and typedef instr_t.
- Local to this block: FSM enum sched_state_e {IDLE, WAIT, DRAIN}.
- One sub-module: sync_fifo (parameterised width/depth; push/pop/full/empty/head, synchronous active-high reset, flush).

Test Plan:
- Reset, then push 3 instructions 0xA1,0xA2,0xA3 with ATOMIC=0 and exec_req_i=0 -> mem_load_o high 3 consecutive cycles starting 1 cycle after the first push, mem_instr_o A1,A2,A3; busy_o returns 0.
- ATOMIC=1: push 16 instrs with vblank_i=0 -> no mem_load_o. Raise vblank_i with hold_i=1 -> still none. Drop hold_i -> 16 loads in order, then prog_done_o pulses once.
- Drain with exec_req_i toggling 1,0,1,0 -> loads only in the exec_req_i=0 cycles; mem_shift_o high on all 4 cycles; no entry lost or duplicated.
- Fill the FIFO to DEPTH, then offer one more -> wr_ready_o=0, write dropped, overflow_o=1 sticky through a subsequent full drain.
- Assert flush_i with 5 pending entries plus a simultaneous push -> next cycle empty, busy_o=0, no mem_load_o afterwards.
- Assert rst_i mid-drain after 4 of 10 pops -> outputs at reset values next cycle, and no further loads.

Source files
------------

// File: rtl/shader_pkg.sv
// Shared shader constants and the instruction type used by the shader top level.
package shader_pkg;
    localparam int INSTR_W   = 8;
    localparam int NUM_INSTR = 16;

    typedef logic [INSTR_W-1:0] instr_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count, head-of-queue output and a flush that
// behaves like a one-cycle reset. Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count == (AW+1)'(DEPTH));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign head_o  = mem[rd_ptr];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i && !flush_i) mem[wr_ptr] <= din_i;
    end
endmodule

// File: rtl/shader_load_scheduler.sv
// Arbitrates the shader instruction memory between raster shifts (always first)
// and buffered SPI instruction writes, which are committed only in safe windows.
//
//   state | meaning
//   IDLE  | nothing buffered, memory driven by raster only
//   WAIT  | writes buffered, waiting for a commit window
//   DRAIN | window open, one buffered write committed per cycle
module shader_load_scheduler
    import shader_pkg::*;
#(
    parameter int NUM_INSTR = shader_pkg::NUM_INSTR,
    parameter int DEPTH     = 16,
    parameter int INSTR_W   = shader_pkg::INSTR_W,
    parameter int ATOMIC    = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_valid_i,
    input  logic [INSTR_W-1:0] wr_instr_i,
    output logic               wr_ready_o,
    input  logic               hold_i,
    input  logic               exec_req_i,
    input  logic               vblank_i,
    input  logic               flush_i,
    output logic               mem_shift_o,
    output logic               mem_load_o,
    output logic [INSTR_W-1:0] mem_instr_o,
    output logic               busy_o,
    output logic               prog_done_o,
    output logic               overflow_o
);
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } sched_state_e;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_INSTR - 1);

    sched_state_e       state;
    sched_state_e       state_nxt;
    logic               full;
    logic               empty;
    logic [AW:0]        count;
    logic [INSTR_W-1:0] head;
    logic               push;
    logic               pop;
    logic               window;
    logic               last_pop;
    logic [CW-1:0]      commit_cnt;

    sync_fifo #(
        .W     (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (wr_instr_i),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // A full FIFO rejects an offer even when a pop frees a slot that cycle.
    assign push = wr_valid_i && !full && !flush_i;

    always_comb begin
        if (ATOMIC != 0) window = vblank_i && !hold_i && !exec_req_i;
        else             window = !exec_req_i;
    end

    assign pop      = !empty && window && (state != IDLE) && !flush_i;
    assign last_pop = pop && (count == (AW+1)'(1)) && !push;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        mem_shift_o = exec_req_i | pop;
        mem_load_o  = pop;
        mem_instr_o = empty ? '0 : head;
        busy_o      = (state != IDLE);
        wr_ready_o  = !full;

        if (flush_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (push || !empty) state_nxt = WAIT;
                end
                WAIT: begin
                    if (last_pop)     state_nxt = IDLE;
                    else if (pop)     state_nxt = DRAIN;
                    else if (empty && !push) state_nxt = IDLE;
                end
                DRAIN: begin
                    if (last_pop)            state_nxt = IDLE;
                    else if (empty && !push) state_nxt = IDLE;
                    else if (!window)        state_nxt = WAIT;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Commit counter tracks position within the program; wrap marks completion.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            commit_cnt  <= '0;
            prog_done_o <= 1'b0;
        end else begin
            prog_done_o <= pop && (commit_cnt == LAST_IDX);
            if (pop) begin
                if (commit_cnt == LAST_IDX) commit_cnt <= '0;
                else                        commit_cnt <= commit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)                    overflow_o <= 1'b0;
        else if (wr_valid_i && full)  overflow_o <= 1'b1;
    end
endmodule

// File: tb/tb_shader_load_scheduler.sv
// Directed bench for shader_load_scheduler: ATOMIC=0 and ATOMIC=1 instances share inputs.
module tb_shader_load_scheduler;
    import shader_pkg::*;

    logic   clk = 1'b0;
    always #5 clk = ~clk;

    logic   rst, wr_valid, hold, exec, vblank, flush;
    instr_t wr_instr;

    logic   wr_ready0, shift0, load0, busy0, done0, ovf0;
    logic   wr_ready1, shift1, load1, busy1, done1, ovf1;
    instr_t instr0, instr1;

    int n_vec  = 0;
    int n_miss = 0;

    shader_load_scheduler #(.NUM_INSTR(16), .DEPTH(16), .INSTR_W(8), .ATOMIC(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_instr_i(wr_instr),
        .wr_ready_o(wr_ready0), .hold_i(hold), .exec_req_i(exec), .vblank_i(vblank),
        .flush_i(flush), .mem_shift_o(shift0), .mem_load_o(load0), .mem_instr_o(instr0),
        .busy_o(busy0), .prog_done_o(done0), .overflow_o(ovf0)
    );

    shader_load_scheduler #(.NUM_INSTR(16), .DEPTH(16), .INSTR_W(8), .ATOMIC(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_instr_i(wr_instr),
        .wr_ready_o(wr_ready1), .hold_i(hold), .exec_req_i(exec), .vblank_i(vblank),
        .flush_i(flush), .mem_shift_o(shift1), .mem_load_o(load1), .mem_instr_o(instr1),
        .busy_o(busy1), .prog_done_o(done1), .overflow_o(ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_valid = 1'b0; wr_instr = '0; hold = 1'b0;
        exec = 1'b0; vblank = 1'b0; flush = 1'b0;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // reset state, shift follows exec_req combinationally
        #1;
        chk("rst_ready", wr_ready0, 1);
        chk("rst_load", load0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_done", done0, 0);
        chk("rst_shift_lo", shift0, 0);
        exec = 1'b1;
        #1;
        chk("rst_shift_hi", shift0, 1);
        exec = 1'b0;
        nxt();

        // ATOMIC=0 three-write drain; ATOMIC=1 instance must hold off outside vblank
        wr_valid = 1'b1; wr_instr = 8'hA1;
        #1;
        chk("t1_load_c0", load0, 0);
        nxt();
        wr_instr = 8'hA2;
        #1;
        chk("t1_load_c1", load0, 1);
        chk("t1_instr_c1", instr0, 8'hA1);
        nxt();
        wr_instr = 8'hA3;
        #1;
        chk("t1_load_c2", load0, 1);
        chk("t1_instr_c2", instr0, 8'hA2);
        chk("t1_atomic_noload", load1, 0);
        nxt();
        wr_valid = 1'b0;
        #1;
        chk("t1_load_c3", load0, 1);
        chk("t1_instr_c3", instr0, 8'hA3);
        nxt();
        #1;
        chk("t1_load_c4", load0, 0);
        chk("t1_busy_c4", busy0, 0);
        chk("t1_atomic_busy", busy1, 1);
        chk("t1_atomic_noload_end", load1, 0);

        // ATOMIC=1: 16 writes outside vblank, hold blocks, then ordered commit
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1; wr_instr = 8'(8'h10 + i);
            #1;
            chk("t2_fill_noload", load1, 0);
            nxt();
        end
        wr_valid = 1'b0;
        #1;
        chk("t2_full_ready", wr_ready1, 0);
        vblank = 1'b1; hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_hold_noload", load1, 0);
            chk("t2_hold_busy", busy1, 1);
            nxt();
        end
        hold = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin
                $display("note: vblank ended mid-program, ATOMIC drain pauses until next vblank");
                vblank = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    #1;
                    chk("t2_pause_noload", load1, 0);
                    chk("t2_pause_busy", busy1, 1);
                    nxt();
                end
                vblank = 1'b1;
            end
            #1;
            chk("t2_load", load1, 1);
            chk("t2_instr", instr1, 8'h10 + i);
            chk("t2_done_early", done1, 0);
            nxt();
        end
        #1;
        chk("t2_done_pulse", done1, 1);
        chk("t2_load_after", load1, 0);
        nxt();
        #1;
        chk("t2_done_clear", done1, 0);
        chk("t2_busy_end", busy1, 0);
        vblank = 1'b0;

        // exec_req toggling during drain: loads only in exec-free cycles
        do_reset();
        exec = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_instr = 8'(8'hB0 + i);
            #1;
            chk("t3_fill_shift", shift0, 1);
            chk("t3_fill_noload", load0, 0);
            nxt();
        end
        wr_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exec = (k % 2 == 0);
            #1;
            chk("t3_shift", shift0, 1);
            if (k % 2 == 0) begin
                chk("t3_exec_noload", load0, 0);
            end else begin
                chk("t3_load", load0, 1);
                chk("t3_instr", instr0, 8'hB0 + k / 2);
            end
            nxt();
        end
        exec = 1'b0;
        #1;
        chk("t3_load_end", load0, 0);
        chk("t3_busy_end", busy0, 0);
        chk("t3_shift_end", shift0, 0);

        // overflow: fill to DEPTH, extra offer during the first pop is rejected
        do_reset();
        exec = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1; wr_instr = 8'(8'hC0 + i);
            nxt();
        end
        wr_valid = 1'b0;
        #1;
        chk("t4_full_ready", wr_ready0, 0);
        chk("t4_ovf_pre", ovf0, 0);
        exec = 1'b0; wr_valid = 1'b1; wr_instr = 8'hEE;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("t4_load", load0, 1);
            chk("t4_instr", instr0, 8'hC0 + i);
            if (i == 0) chk("t4_ready_full", wr_ready0, 0);
            if (i > 0)  chk("t4_ovf_sticky", ovf0, 1);
            nxt();
            wr_valid = 1'b0;
        end
        #1;
        chk("t4_load_end", load0, 0);
        chk("t4_busy_end", busy0, 0);
        chk("t4_ovf_end", ovf0, 1);
        chk("t4_done", done0, 1);

        // flush with 5 pending plus a simultaneous push
        do_reset();
        exec = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_instr = 8'(8'h50 + i);
            nxt();
        end
        exec = 1'b0; flush = 1'b1; wr_instr = 8'h77;
        #1;
        chk("t5_flush_nopop", load0, 0);
        nxt();
        flush = 1'b0; wr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_busy", busy0, 0);
            chk("t5_noload", load0, 0);
            chk("t5_instr", instr0, 0);
            chk("t5_ready", wr_ready0, 1);
            nxt();
        end

        // reset after 4 of 10 commits
        do_reset();
        exec = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1; wr_instr = 8'(8'hD0 + i);
            nxt();
        end
        wr_valid = 1'b0; exec = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t6_load", load0, 1);
            chk("t6_instr", instr0, 8'hD0 + i);
            nxt();
        end
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t6_noload", load0, 0);
            chk("t6_busy", busy0, 0);
            chk("t6_instr", instr0, 0);
            chk("t6_ready", wr_ready0, 1);
            chk("t6_ovf", ovf0, 0);
            chk("t6_done", done0, 0);
            nxt();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
